// File: rtl/fp_alu_sequencer.sv
// Command sequencer for a shared combinational fixed-point ALU and an external inverse-sqrt unit.
// Optional build macro: ALU_SEQ_ISQRT_TIMEOUT_EN (abort a stalled inverse-sqrt after ISQRT_TIMEOUT cycles).
`ifndef WIDTH
`define WIDTH 32
`endif

module fp_alu_sequencer #(
    parameter int NREGS         = 8,
    parameter int ISQRT_TIMEOUT = 255,
    parameter int AW            = $clog2(NREGS)
) (
    input  logic                clk_in,
    input  logic                rst_in,

    input  logic                wr_en_in,
    input  logic [AW-1:0]       wr_addr_in,
    input  logic [`WIDTH-1:0]   wr_data_in,

    input  logic                cmd_valid_in,
    output logic                cmd_ready_out,
    input  logic [2:0]          cmd_op_in,
    input  logic [AW-1:0]       cmd_a_in,
    input  logic [AW-1:0]       cmd_b_in,
    input  logic [AW-1:0]       cmd_dst_in,

    output logic [`WIDTH-1:0]   alu_d1_out,
    output logic [`WIDTH-1:0]   alu_d0_out,
    output logic [2:0]          alu_sel_out,
    input  logic [`WIDTH-1:0]   alu_res_in,
    input  logic                alu_gt_in,
    input  logic                alu_eq_in,

    output logic                isqrt_req_out,
    output logic [`WIDTH-1:0]   isqrt_d_out,
    input  logic                isqrt_ack_in,
    input  logic [`WIDTH-1:0]   isqrt_res_in,

    output logic                res_valid_out,
    input  logic                res_ready_in,
    output logic [`WIDTH-1:0]   res_data_out,
    output logic                res_gt_out,
    output logic                res_eq_out,
    output logic                res_err_out
);

    localparam int         W          = `WIDTH;
    localparam logic [2:0] OP_ISQRT   = 3'b010;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        ISQRT,
        RESP
    } state_t;

    state_t          state;
    logic [W-1:0]    regs [NREGS];
    logic [AW-1:0]   dst;

`ifdef ALU_SEQ_ISQRT_TIMEOUT_EN
    localparam int CW = $clog2(ISQRT_TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
`endif

    // Register 0 is hard-wired to zero regardless of what the array holds.
    function automatic logic [W-1:0] rd(input logic [AW-1:0] addr);
        return (addr == '0) ? '0 : regs[addr];
    endfunction

    // NOTE: all state below uses non-blocking assignments, so every read in a
    // clock cycle sees the pre-edge value; this is what makes a host write that
    // coincides with a command accept leave the latched operands untouched.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= IDLE;
            dst           <= '0;
            cmd_ready_out <= 1'b1;
            alu_d1_out    <= '0;
            alu_d0_out    <= '0;
            alu_sel_out   <= '0;
            isqrt_req_out <= 1'b0;
            isqrt_d_out   <= '0;
            res_valid_out <= 1'b0;
            res_data_out  <= '0;
            res_gt_out    <= 1'b0;
            res_eq_out    <= 1'b0;
            res_err_out   <= 1'b0;
`ifdef ALU_SEQ_ISQRT_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
            // NOTE: the register file is cleared by reset because software relies
            // on every register reading zero after reset, so it maps to flops, not RAM.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_en_in && (wr_addr_in != '0)) begin
                        regs[wr_addr_in] <= wr_data_in;
                    end
                    if (cmd_valid_in && cmd_ready_out) begin
                        cmd_ready_out <= 1'b0;
                        alu_d1_out    <= rd(cmd_a_in);
                        alu_d0_out    <= rd(cmd_b_in);
                        alu_sel_out   <= cmd_op_in;
                        dst           <= cmd_dst_in;
                        if (cmd_op_in == OP_ISQRT) begin
                            isqrt_req_out <= 1'b1;
                            isqrt_d_out   <= rd(cmd_a_in);
`ifdef ALU_SEQ_ISQRT_TIMEOUT_EN
                            wait_cnt      <= '0;
`endif
                            state         <= ISQRT;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end

                EXEC: begin
                    res_gt_out    <= alu_gt_in;
                    res_eq_out    <= alu_eq_in;
                    res_valid_out <= 1'b1;
                    if (alu_sel_out == OP_ILLEGAL) begin
                        res_data_out <= '0;
                        res_err_out  <= 1'b1;
                    end else begin
                        res_data_out <= alu_res_in;
                        res_err_out  <= 1'b0;
                        if (dst != '0) begin
                            regs[dst] <= alu_res_in;
                        end
                    end
                    state <= RESP;
                end

                ISQRT: begin
                    if (isqrt_ack_in) begin
                        isqrt_req_out <= 1'b0;
                        res_data_out  <= isqrt_res_in;
                        res_gt_out    <= 1'b0;
                        res_eq_out    <= 1'b0;
                        res_err_out   <= 1'b0;
                        res_valid_out <= 1'b1;
                        if (dst != '0) begin
                            regs[dst] <= isqrt_res_in;
                        end
                        state <= RESP;
                    end
`ifdef ALU_SEQ_ISQRT_TIMEOUT_EN
                    // The count covers the cycles req has been high; abort on the last one.
                    else if (wait_cnt == CW'(ISQRT_TIMEOUT - 1)) begin
                        isqrt_req_out <= 1'b0;
                        res_data_out  <= '0;
                        res_gt_out    <= 1'b0;
                        res_eq_out    <= 1'b0;
                        res_err_out   <= 1'b1;
                        res_valid_out <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    if (res_ready_in) begin
                        res_valid_out <= 1'b0;
                        cmd_ready_out <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_alu_sequencer.sv
// Self-checking bench for fp_alu_sequencer: table-driven ALU vectors, a response scoreboard,
// and hand-written inverse-sqrt, backpressure, reset and (with ALU_SEQ_ISQRT_TIMEOUT_EN) timeout sequences.
`timescale 1ns/1ps
`ifndef WIDTH
`define WIDTH 32
`endif

module tb_fp_alu_sequencer;

    localparam int W  = `WIDTH;
    localparam int AW = 3;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_MUL   = 3'b001;
    localparam logic [2:0] OP_ISQRT = 3'b010;
    localparam logic [2:0] OP_MAX   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_SIGN  = 3'b101;
    localparam logic [2:0] OP_MIN   = 3'b110;
    localparam logic [2:0] OP_ILL   = 3'b111;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          wr_en_in;
    logic [AW-1:0] wr_addr_in;
    logic [W-1:0]  wr_data_in;
    logic          cmd_valid_in;
    logic          cmd_ready_out;
    logic [2:0]    cmd_op_in;
    logic [AW-1:0] cmd_a_in, cmd_b_in, cmd_dst_in;
    logic [W-1:0]  alu_d1_out, alu_d0_out;
    logic [2:0]    alu_sel_out;
    logic [W-1:0]  alu_res_in;
    logic          alu_gt_in, alu_eq_in;
    logic          isqrt_req_out;
    logic [W-1:0]  isqrt_d_out;
    logic          isqrt_ack_in;
    logic [W-1:0]  isqrt_res_in;
    logic          res_valid_out;
    logic          res_ready_in;
    logic [W-1:0]  res_data_out;
    logic          res_gt_out, res_eq_out, res_err_out;

    fp_alu_sequencer dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .wr_en_in      (wr_en_in),
        .wr_addr_in    (wr_addr_in),
        .wr_data_in    (wr_data_in),
        .cmd_valid_in  (cmd_valid_in),
        .cmd_ready_out (cmd_ready_out),
        .cmd_op_in     (cmd_op_in),
        .cmd_a_in      (cmd_a_in),
        .cmd_b_in      (cmd_b_in),
        .cmd_dst_in    (cmd_dst_in),
        .alu_d1_out    (alu_d1_out),
        .alu_d0_out    (alu_d0_out),
        .alu_sel_out   (alu_sel_out),
        .alu_res_in    (alu_res_in),
        .alu_gt_in     (alu_gt_in),
        .alu_eq_in     (alu_eq_in),
        .isqrt_req_out (isqrt_req_out),
        .isqrt_d_out   (isqrt_d_out),
        .isqrt_ack_in  (isqrt_ack_in),
        .isqrt_res_in  (isqrt_res_in),
        .res_valid_out (res_valid_out),
        .res_ready_in  (res_ready_in),
        .res_data_out  (res_data_out),
        .res_gt_out    (res_gt_out),
        .res_eq_out    (res_eq_out),
        .res_err_out   (res_err_out)
    );

    always #5 clk_in = ~clk_in;

    // Combinational ALU stub; illegal/isqrt selects return junk that must never reach a result.
    always_comb begin
        alu_gt_in = ($signed(alu_d1_out) > $signed(alu_d0_out));
        alu_eq_in = (alu_d1_out == alu_d0_out);
        case (alu_sel_out)
            OP_ADD:  alu_res_in = alu_d1_out + alu_d0_out;
            OP_MUL:  alu_res_in = alu_d1_out * alu_d0_out;
            OP_MAX:  alu_res_in = alu_gt_in ? alu_d1_out : alu_d0_out;
            OP_SUB:  alu_res_in = alu_d1_out - alu_d0_out;
            OP_SIGN: alu_res_in = alu_d1_out[W-1] ? '1 : ((alu_d1_out == '0) ? '0 : W'(1));
            OP_MIN:  alu_res_in = alu_gt_in ? alu_d0_out : alu_d1_out;
            default: alu_res_in = 32'hBAD0_BAD0;
        endcase
    end

    typedef struct {
        logic [W-1:0] data;
        logic         gt;
        logic         eq;
        logic         err;
        logic         flags;   // compare gt/eq only when set
    } exp_t;

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] a, b, dst;
        exp_t          exp;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted response is compared against the oldest pushed expectation.
    always @(negedge clk_in) begin
        if (!rst_in && res_valid_out && res_ready_in) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got response %h, expected none", res_data_out);
            end else begin
                mon_e = sb.pop_front();
                check("res_data", res_data_out, mon_e.data);
                check_bit("res_err", res_err_out, mon_e.err);
                if (mon_e.flags) begin
                    check_bit("res_gt", res_gt_out, mon_e.gt);
                    check_bit("res_eq", res_eq_out, mon_e.eq);
                end
            end
        end
    end

    task automatic write_reg(input logic [AW-1:0] addr, input logic [W-1:0] data);
        wr_en_in   = 1'b1;
        wr_addr_in = addr;
        wr_data_in = data;
        @(posedge clk_in); #1;
        wr_en_in   = 1'b0;
    endtask

    // Returns #1 after the accepting edge.
    task automatic send_cmd(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [AW-1:0] dst);
        bit ok = 0;
        cmd_valid_in = 1'b1;
        cmd_op_in    = op;
        cmd_a_in     = a;
        cmd_b_in     = b;
        cmd_dst_in   = dst;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            if (cmd_ready_out) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_bit("cmd_accept_timeout", 1'b0, 1'b1);
        @(posedge clk_in); #1;
        cmd_valid_in = 1'b0;
    endtask

    task automatic wait_resp(input int limit);
        bit ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_in);
            if (res_valid_out && res_ready_in) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_bit("resp_timeout", 1'b0, 1'b1);
        @(posedge clk_in); #1;
    endtask

    // ALU op with latency check: idle-ready low and no valid in EXEC, valid exactly at accept+2.
    task automatic run_alu(input vec_t v);
        sb.push_back(v.exp);
        send_cmd(v.op, v.a, v.b, v.dst);
        @(negedge clk_in);
        check_bit("lat_exec_valid", res_valid_out, 1'b0);
        check_bit("lat_exec_ready", cmd_ready_out, 1'b0);
        @(negedge clk_in);
        check_bit("lat_resp_valid", res_valid_out, 1'b1);
        @(posedge clk_in); #1;
    endtask

    // Counts cycles with req high, checking the operand; acks on cycle ack_after (0 = never).
    task automatic isqrt_stub(input int ack_after, input logic [W-1:0] exp_d, input int limit,
                              output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_in);
            if (!isqrt_req_out) break;
            n++;
            if (n == 1 || n == ack_after) check("isqrt_d", isqrt_d_out, exp_d);
            isqrt_ack_in = (ack_after != 0) && (n == ack_after);
        end
        isqrt_ack_in = 1'b0;
    endtask

    vec_t vecs[9];
    int   n_req;

    initial begin
        vecs[0] = '{OP_ADD,  3'd1, 3'd2, 3'd3, '{32'h0000_0180, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[1] = '{OP_SUB,  3'd2, 3'd1, 3'd4, '{32'hFFFF_FF80, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[2] = '{OP_MAX,  3'd1, 3'd2, 3'd5, '{32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[3] = '{OP_MIN,  3'd1, 3'd1, 3'd6, '{32'h0000_0100, 1'b0, 1'b1, 1'b0, 1'b1}};
        vecs[4] = '{OP_ADD,  3'd3, 3'd0, 3'd7, '{32'h0000_0180, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[5] = '{OP_ADD,  3'd4, 3'd4, 3'd7, '{32'hFFFF_FF00, 1'b0, 1'b1, 1'b0, 1'b1}};
        vecs[6] = '{OP_ILL,  3'd1, 3'd2, 3'd5, '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[7] = '{OP_ADD,  3'd5, 3'd0, 3'd1, '{32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[8] = '{OP_MUL,  3'd2, 3'd2, 3'd6, '{32'h0000_4000, 1'b0, 1'b1, 1'b0, 1'b1}};

        rst_in = 1'b1;
        wr_en_in = 1'b0; wr_addr_in = '0; wr_data_in = '0;
        cmd_valid_in = 1'b0; cmd_op_in = '0; cmd_a_in = '0; cmd_b_in = '0; cmd_dst_in = '0;
        isqrt_ack_in = 1'b0; isqrt_res_in = 32'h0000_0055;
        res_ready_in = 1'b1;

        #12;
        check_bit("rst_cmd_ready", cmd_ready_out, 1'b1);
        check_bit("rst_res_valid", res_valid_out, 1'b0);
        check_bit("rst_isqrt_req", isqrt_req_out, 1'b0);
        check("rst_res_data", res_data_out, '0);
        check("rst_alu_d1", alu_d1_out, '0);
        check_bit("rst_res_err", res_err_out, 1'b0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        write_reg(3'd1, 32'h0000_0100);
        write_reg(3'd2, 32'h0000_0080);

        foreach (vecs[i]) run_alu(vecs[i]);
        run_alu('{OP_SIGN, 3'd4, 3'd0, 3'd6, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1}});

        // Inverse sqrt acked on the fifth request cycle, then read back the destination.
        sb.push_back('{32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b1});
        send_cmd(OP_ISQRT, 3'd1, 3'd0, 3'd3);
        isqrt_stub(5, 32'h0000_0100, 50, n_req);
        check("isqrt_req_cycles", W'(n_req), W'(5));
        @(posedge clk_in); #1;
        run_alu('{OP_ADD, 3'd3, 3'd0, 3'd4, '{32'h0000_0055, 1'b1, 1'b0, 1'b0, 1'b1}});

        // Backpressure: result held 4 cycles, host writes ignored outside IDLE.
        res_ready_in = 1'b0;
        sb.push_back('{32'h0000_0180, 1'b1, 1'b0, 1'b0, 1'b1});
        send_cmd(OP_ADD, 3'd1, 3'd2, 3'd5);
        wr_en_in = 1'b1; wr_addr_in = 3'd5; wr_data_in = 32'hDEAD_BEEF;
        @(negedge clk_in);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            check_bit("bp_valid", res_valid_out, 1'b1);
            check("bp_data", res_data_out, 32'h0000_0180);
            check_bit("bp_cmd_ready", cmd_ready_out, 1'b0);
        end
        @(posedge clk_in); #1;
        wr_en_in = 1'b0;
        res_ready_in = 1'b1;
        wait_resp(5);
        @(negedge clk_in);
        check_bit("bp_valid_fall", res_valid_out, 1'b0);
        check_bit("bp_ready_back", cmd_ready_out, 1'b1);
        @(posedge clk_in); #1;
        run_alu('{OP_ADD, 3'd5, 3'd0, 3'd6, '{32'h0000_0180, 1'b1, 1'b0, 1'b0, 1'b1}});

        // Host write coinciding with accept: operand sees the old value, next op the new one.
        wr_en_in = 1'b1; wr_addr_in = 3'd2; wr_data_in = 32'h0000_0999;
        sb.push_back('{32'h0000_0080, 1'b1, 1'b0, 1'b0, 1'b1});
        send_cmd(OP_ADD, 3'd2, 3'd0, 3'd6);
        wr_en_in = 1'b0;
        wait_resp(10);
        run_alu('{OP_ADD, 3'd2, 3'd0, 3'd6, '{32'h0000_0999, 1'b1, 1'b0, 1'b0, 1'b1}});

        // Register 0 stays zero.
        write_reg(3'd0, 32'h0000_1234);
        run_alu('{OP_ADD, 3'd0, 3'd0, 3'd7, '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1}});

`ifdef ALU_SEQ_ISQRT_TIMEOUT_EN
        // No ack: abort after 255 request cycles, no writeback, late ack ignored.
        sb.push_back('{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0});
        send_cmd(OP_ISQRT, 3'd1, 3'd0, 3'd2);
        isqrt_stub(0, 32'h0000_0100, 400, n_req);
        check("timeout_cycles", W'(n_req), W'(255));
        @(posedge clk_in); #1;
        isqrt_res_in = 32'h0000_0777;
        isqrt_ack_in = 1'b1;
        @(posedge clk_in); #1;
        isqrt_ack_in = 1'b0;
        run_alu('{OP_ADD, 3'd2, 3'd0, 3'd3, '{32'h0000_0999, 1'b1, 1'b0, 1'b0, 1'b1}});
`endif

        // Asynchronous reset in the middle of an unanswered inverse-sqrt request.
        send_cmd(OP_ISQRT, 3'd1, 3'd0, 3'd3);
        repeat (3) @(negedge clk_in);
        check_bit("pre_rst_req", isqrt_req_out, 1'b1);
        #2;
        rst_in = 1'b1;
        #1;
        check_bit("arst_isqrt_req", isqrt_req_out, 1'b0);
        check_bit("arst_cmd_ready", cmd_ready_out, 1'b1);
        check_bit("arst_res_valid", res_valid_out, 1'b0);
        check("arst_isqrt_d", isqrt_d_out, '0);
        check("arst_alu_d1", alu_d1_out, '0);
        sb.delete();
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        run_alu('{OP_ADD, 3'd1, 3'd2, 3'd3, '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1}});
        run_alu('{OP_ADD, 3'd5, 3'd6, 3'd3, '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1}});

        repeat (2) @(posedge clk_in);
        check("sb_drained", W'(sb.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_alu_sequencer.md
Name: fp_alu_sequencer

Overview:
Initiator/driver end of the shared combinational fixed-point ALU interface (d0/d1/sel in; res/gt/eq out). Accepts operation commands over a valid/ready handshake and reads operands from a small internal register file. Drives the ALU, or an external multi-cycle inverse-sqrt unit for opcode 3'b010, then writes the result back and returns it over a second valid/ready handshake. Sits between the ray-march control FSM and the arithmetic datapath.

Parameters:
NREGS, 8, number of `WIDTH-bit signed fixed-point registers; address width AW = $clog2(NREGS).
ISQRT_TIMEOUT, 255, cycles to wait for isqrt_ack_in before abort; used only with the optional feature.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
wr_en_in  input  1  host register load; honoured only in IDLE
wr_addr_in  input  AW  load address
wr_data_in  input  `WIDTH  load data
cmd_valid_in  input  1  command valid
cmd_ready_out  output  1  high only in IDLE
cmd_op_in  input  3  ALU opcode: 000 add, 001 mul, 010 isqrt, 011 max, 100 sub, 101 sign, 110 min, 111 illegal
cmd_a_in  input  AW  register index of operand A
cmd_b_in  input  AW  register index of operand B
cmd_dst_in  input  AW  destination register index
alu_d1_out  output  `WIDTH  operand A to ALU (registered)
alu_d0_out  output  `WIDTH  operand B to ALU (registered)
alu_sel_out  output  3  opcode to ALU (registered)
alu_res_in  input  `WIDTH  ALU result
alu_gt_in  input  1  ALU A>B flag
alu_eq_in  input  1  ALU A==B flag
isqrt_req_out  output  1  inverse-sqrt request
isqrt_d_out  output  `WIDTH  inverse-sqrt operand (operand A)
isqrt_ack_in  input  1  one-cycle pulse; result valid
isqrt_res_in  input  `WIDTH  inverse-sqrt result
res_valid_out  output  1  result valid
res_ready_in  input  1  result accepted
res_data_out  output  `WIDTH  result value
res_gt_out  output  1  captured gt flag
res_eq_out  output  1  captured eq flag
res_err_out  output  1  illegal opcode or timeout

Behaviour:
- Reset (async, immediate): state IDLE; all registers 0; all outputs 0 except cmd_ready_out=1. A reset during ISQRT drops isqrt_req_out at once.
- Register 0 reads as zero always; writes to it (host or result) are dropped.
- FSM states IDLE, EXEC, ISQRT, RESP.
- IDLE: accept on cmd_valid_in & cmd_ready_out. Latch alu_d1_out=reg[a], alu_d0_out=reg[b], alu_sel_out=op, dst.
  - op 010 -> ISQRT, with isqrt_req_out=1 and isqrt_d_out=reg[a].
  - Otherwise -> EXEC.
  - wr_en_in in IDLE writes the register file. If it coincides with an accepted command, operands read the pre-write value.
- EXEC (1 cycle): capture alu_res_in/gt/eq into the res_* registers and write reg[dst]; then RESP.
  - op 111: res_data=0, err=1, no writeback.
- ISQRT: hold isqrt_req_out high and isqrt_d_out stable until isqrt_ack_in. On ack, capture isqrt_res_in, write reg[dst], gt=eq=0, drop req, go to RESP.
- RESP: res_valid_out=1 with outputs stable until res_ready_in; then -> IDLE. res_valid_out falls the following cycle.
- Latency, ALU ops: command accepted at cycle N, res_valid_out high at N+2. Back-to-back throughput is one op per 3 cycles with res_ready_in tied high.
- wr_en_in outside IDLE is ignored.
- Dependent ops (dst == next a/b) need no hazard handling: writeback completes before the next accept.

Optional Feature:
ALU_SEQ_ISQRT_TIMEOUT_EN: when defined, a counter runs in ISQRT. After ISQRT_TIMEOUT cycles without ack, drop req, set res_data=0 and res_err=1, skip writeback, go to RESP. A late ack arriving after the abort is ignored in every state except ISQRT. When undefined, ISQRT waits indefinitely and res_err_out is set only for op 111.

Test Plan:
- Load r1=0x0000_0100, r2=0x0000_0080; cmd add a=1,b=2,dst=3 -> res_data=0x180 at accept+2; r3=0x180.
- sub a=2,b=1,dst=4 -> res_data=0xFFFF_FF80 (-0x80); then max a=1,b=2 -> 0x100 with gt=1,eq=0; min a=1,b=1 -> 0x100 with eq=1.
- isqrt a=1 with stub acking after 5 cycles returning 0x55 -> req high exactly 5 cycles, isqrt_d=0x100, res=0x55; then add a=dst,b=0 -> 0x55.
- res_ready_in held low 4 cycles -> res_valid/res_data stable, cmd_ready_out=0, wr_en_in ignored (register unchanged).
- op 111 -> res_err=1, res_data=0, dst unchanged; write to r0 then add a=0,b=0 -> 0.
- Async reset asserted mid-ISQRT -> isqrt_req_out=0 same cycle, all registers 0, cmd_ready_out=1. With ALU_SEQ_ISQRT_TIMEOUT_EN and no ack -> err=1 after 255 cycles.
